seg7_readback: RTL and testbench

- Receive-side counterpart to the team's hex-to-7-segment decoders: observes a multiplexed, active-low 7-segment bus (segment lines plus one-hot digit enables) and reconstructs the 4-bit hex value shown on each digit.
- Used in self-check benches and on-board loopback to confirm that the display path drives what the datapath intended.
- Qualifies each digit by stability, decodes it, stores it per digit, and publishes a complete-frame snapshot with a ready/ack handshake.

---
 rtl/seg7_readback.sv | 254 +++++++++++++++++++++++++
 tb/tb_seg7_readback.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback.sv
// Reconstructs hex digits from a multiplexed active-low 7-segment bus and publishes full-frame snapshots.
// Optional decimal-point capture is enabled with `define SEG7_DP_EN.
module seg7_readback #(
    parameter int NUM_DIG    = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             seg,
`ifdef SEG7_DP_EN
    input  logic                   dp,
    output logic [NUM_DIG-1:0]     frame_dp,
`endif
    input  logic [NUM_DIG-1:0]     an,
    output logic [4*NUM_DIG-1:0]   frame,
    output logic                   frame_rdy,
    input  logic                   frame_ack,
    output logic                   err,
    input  logic                   err_clr
);

    localparam int         IW       = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [7:0] STABLE_L = 8'(STABLE_CYC);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_QUAL  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Returns {valid, value} for an active-high gfedcba on-pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] on_pat);
        logic [4:0] r;
        case (on_pat)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    function automatic logic [IW-1:0] dig_idx(input logic [NUM_DIG-1:0] a);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (a[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    logic                 dp_in_s;
`ifdef SEG7_DP_EN
    assign dp_in_s = dp;
    logic [NUM_DIG-1:0]   work_dp_q, work_dp_d;
    logic [NUM_DIG-1:0]   frame_dp_q, frame_dp_d;
    assign frame_dp = frame_dp_q;
`else
    assign dp_in_s = 1'b1;
`endif

    state_t               state_q, state_d;
    logic [NUM_DIG-1:0]   an_s_q, an_s_d;
    logic [6:0]           seg_s_q, seg_s_d;
    logic                 dp_s_q, dp_s_d;
    logic [NUM_DIG-1:0]   cand_an_q, cand_an_d;
    logic [6:0]           cand_seg_q, cand_seg_d;
    logic                 cand_dp_q, cand_dp_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [4*NUM_DIG-1:0] work_q, work_d;
    logic [NUM_DIG-1:0]   seen_q, seen_d;
    logic [4*NUM_DIG-1:0] frame_q, frame_d;
    logic                 frame_rdy_q, frame_rdy_d;
    logic                 err_q, err_d;

    logic                 match_s;
    logic                 qual_err_s;
    logic [NUM_DIG-1:0]   qual_bit_s;
    logic [4:0]           dec_s;
    logic [IW-1:0]        idx_s;
    logic                 publish_s;

    assign frame     = frame_q;
    assign frame_rdy = frame_rdy_q;
    assign err       = err_q;

    // Next-state logic: input sampling, stability FSM, frame publish and error flag.
    always_comb begin
        state_d     = state_q;
        an_s_d      = an;
        seg_s_d     = seg;
        dp_s_d      = dp_in_s;
        cand_an_d   = cand_an_q;
        cand_seg_d  = cand_seg_q;
        cand_dp_d   = cand_dp_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        frame_d     = frame_q;
        frame_rdy_d = frame_rdy_q;
        qual_err_s  = 1'b0;
        qual_bit_s  = '0;
`ifdef SEG7_DP_EN
        work_dp_d   = work_dp_q;
        frame_dp_d  = frame_dp_q;
`endif
        match_s = (an_s_q == cand_an_q) && (seg_s_q == cand_seg_q) && (dp_s_q == cand_dp_q);
        dec_s   = seg_decode(~cand_seg_q);
        idx_s   = dig_idx(cand_an_q);

        case (state_q)
            ST_WAIT: begin
                cnt_d = 8'd0;
                if ($onehot(an_s_q)) begin
                    cand_an_d  = an_s_q;
                    cand_seg_d = seg_s_q;
                    cand_dp_d  = dp_s_q;
                    if (STABLE_L == 8'd1) begin
                        state_d = ST_QUAL;
                    end else begin
                        cnt_d   = 8'd1;
                        state_d = ST_COUNT;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_COUNT: begin
                if (match_s) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == STABLE_L) begin
                        state_d = ST_QUAL;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end else if ($onehot(an_s_q)) begin
                    // A new stable-looking candidate restarts the dwell count.
                    cand_an_d  = an_s_q;
                    cand_seg_d = seg_s_q;
                    cand_dp_d  = dp_s_q;
                    cnt_d      = 8'd1;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_QUAL: begin
                cnt_d   = 8'd0;
                state_d = ST_HOLD;
                if (dec_s[4]) begin
                    work_d[4*idx_s +: 4] = dec_s[3:0];
                    qual_bit_s           = cand_an_q;
`ifdef SEG7_DP_EN
                    work_dp_d[idx_s]     = ~cand_dp_q;
`endif
                end else begin
                    qual_err_s = 1'b1;
                end
            end
            ST_HOLD: begin
                if (match_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_WAIT;
            end
        endcase

        // An ack in the same cycle as a pending full frame loads it back-to-back.
        publish_s = (&seen_q) && (!frame_rdy_q || frame_ack);
        if (publish_s) begin
            frame_d     = work_q;
            frame_rdy_d = 1'b1;
            seen_d      = qual_bit_s;
`ifdef SEG7_DP_EN
            frame_dp_d  = work_dp_q;
`endif
        end else if (frame_ack) begin
            frame_rdy_d = 1'b0;
            seen_d      = seen_q | qual_bit_s;
        end else begin
            seen_d      = seen_q | qual_bit_s;
        end

        if (qual_err_s) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT;
            an_s_q      <= '0;
            seg_s_q     <= 7'h00;
            dp_s_q      <= 1'b0;
            cand_an_q   <= '0;
            cand_seg_q  <= 7'h00;
            cand_dp_q   <= 1'b0;
            cnt_q       <= 8'd0;
            work_q      <= '0;
            seen_q      <= '0;
            frame_q     <= '0;
            frame_rdy_q <= 1'b0;
            err_q       <= 1'b0;
`ifdef SEG7_DP_EN
            work_dp_q   <= '0;
            frame_dp_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            an_s_q      <= an_s_d;
            seg_s_q     <= seg_s_d;
            dp_s_q      <= dp_s_d;
            cand_an_q   <= cand_an_d;
            cand_seg_q  <= cand_seg_d;
            cand_dp_q   <= cand_dp_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            seen_q      <= seen_d;
            frame_q     <= frame_d;
            frame_rdy_q <= frame_rdy_d;
            err_q       <= err_d;
`ifdef SEG7_DP_EN
            work_dp_q   <= work_dp_d;
            frame_dp_q  <= frame_dp_d;
`endif
        end
    end

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback: table-driven digit scans plus hand-written corner sequences.
module tb_seg7_readback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg_i;
    logic [3:0]  an_i;
    logic [15:0] frame_o;
    logic        frame_rdy_o;
    logic        frame_ack_i;
    logic        err_o;
    logic        err_clr_i;
`ifdef SEG7_DP_EN
    logic        dp_i;
    logic [3:0]  frame_dp_o;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    seg7_readback #(.NUM_DIG(4), .STABLE_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg_i),
`ifdef SEG7_DP_EN
        .dp        (dp_i),
        .frame_dp  (frame_dp_o),
`endif
        .an        (an_i),
        .frame     (frame_o),
        .frame_rdy (frame_rdy_o),
        .frame_ack (frame_ack_i),
        .err       (err_o),
        .err_clr   (err_clr_i)
    );

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  on;
        logic        ack;
        int          ncyc;
        logic        rdy;
        logic [15:0] frame;
        logic        err;
    } step_t;

    step_t tbl[30];

    function automatic step_t mk(input logic [3:0] an, input logic [6:0] on, input logic ack,
                                 input int ncyc, input logic rdy, input logic [15:0] frame);
        step_t s;
        s.an = an; s.on = on; s.ack = ack; s.ncyc = ncyc;
        s.rdy = rdy; s.frame = frame; s.err = 1'b0;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rdy, input logic [15:0] frm, input logic e);
        check({tag, ".rdy"},   {31'd0, frame_rdy_o}, {31'd0, rdy});
        check({tag, ".frame"}, {16'd0, frame_o},     {16'd0, frm});
        check({tag, ".err"},   {31'd0, err_o},       {31'd0, e});
    endtask

    // Present on-pattern 'on' on digit enables 'an' for n cycles (seg lines are active-low).
    task automatic show(input logic [3:0] an, input logic [6:0] on, input int n);
        an_i  = an;
        seg_i = ~on;
        repeat (n) @(negedge clk);
    endtask

    task automatic gap(input int n);
        show(4'b0000, 7'h00, n);
    endtask

    task automatic pulse_ack();
        frame_ack_i = 1'b1;
        gap(1);
        frame_ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        gap(1);
        rst_n = 1'b1;
    endtask

    task automatic show_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3);
        show(4'b0001, p0, 6);
        show(4'b0010, p1, 6);
        show(4'b0100, p2, 6);
        show(4'b1000, p3, 6);
        gap(4);
    endtask

    initial begin
        rst_n       = 1'b0;
        an_i        = 4'b0000;
        seg_i       = 7'h7F;
        frame_ack_i = 1'b0;
        err_clr_i   = 1'b0;
`ifdef SEG7_DP_EN
        dp_i        = 1'b1;
`endif
        tbl[0]  = mk(4'b0001, 7'h3F, 1'b0, 6, 1'b0, 16'h0000);
        tbl[1]  = mk(4'b0010, 7'h06, 1'b0, 6, 1'b0, 16'h0000);
        tbl[2]  = mk(4'b0100, 7'h5B, 1'b0, 6, 1'b0, 16'h0000);
        tbl[3]  = mk(4'b1000, 7'h4F, 1'b0, 6, 1'b0, 16'h0000);
        tbl[4]  = mk(4'b0000, 7'h00, 1'b0, 4, 1'b1, 16'h3210);
        tbl[5]  = mk(4'b0000, 7'h00, 1'b1, 1, 1'b0, 16'h3210);
        tbl[6]  = mk(4'b0001, 7'h66, 1'b0, 6, 1'b0, 16'h3210);
        tbl[7]  = mk(4'b0010, 7'h6D, 1'b0, 6, 1'b0, 16'h3210);
        tbl[8]  = mk(4'b0100, 7'h7D, 1'b0, 6, 1'b0, 16'h3210);
        tbl[9]  = mk(4'b1000, 7'h07, 1'b0, 6, 1'b0, 16'h3210);
        tbl[10] = mk(4'b0000, 7'h00, 1'b0, 4, 1'b1, 16'h7654);
        tbl[11] = mk(4'b0000, 7'h00, 1'b1, 1, 1'b0, 16'h7654);
        tbl[12] = mk(4'b0001, 7'h7F, 1'b0, 6, 1'b0, 16'h7654);
        tbl[13] = mk(4'b0010, 7'h6F, 1'b0, 6, 1'b0, 16'h7654);
        tbl[14] = mk(4'b0100, 7'h77, 1'b0, 6, 1'b0, 16'h7654);
        tbl[15] = mk(4'b1000, 7'h7C, 1'b0, 6, 1'b0, 16'h7654);
        tbl[16] = mk(4'b0000, 7'h00, 1'b0, 4, 1'b1, 16'hBA98);
        tbl[17] = mk(4'b0000, 7'h00, 1'b1, 1, 1'b0, 16'hBA98);
        tbl[18] = mk(4'b0001, 7'h39, 1'b0, 6, 1'b0, 16'hBA98);
        tbl[19] = mk(4'b0010, 7'h5E, 1'b0, 6, 1'b0, 16'hBA98);
        tbl[20] = mk(4'b0100, 7'h79, 1'b0, 6, 1'b0, 16'hBA98);
        tbl[21] = mk(4'b1000, 7'h71, 1'b0, 6, 1'b0, 16'hBA98);
        tbl[22] = mk(4'b0000, 7'h00, 1'b0, 4, 1'b1, 16'hFEDC);
        // Second frame 0x89AB completes while 0xFEDC is still unacknowledged.
        tbl[23] = mk(4'b0001, 7'h7C, 1'b0, 6, 1'b1, 16'hFEDC);
        tbl[24] = mk(4'b0010, 7'h77, 1'b0, 6, 1'b1, 16'hFEDC);
        tbl[25] = mk(4'b0100, 7'h6F, 1'b0, 6, 1'b1, 16'hFEDC);
        tbl[26] = mk(4'b1000, 7'h7F, 1'b0, 6, 1'b1, 16'hFEDC);
        tbl[27] = mk(4'b0000, 7'h00, 1'b0, 4, 1'b1, 16'hFEDC);
        tbl[28] = mk(4'b0000, 7'h00, 1'b1, 1, 1'b1, 16'h89AB);
        tbl[29] = mk(4'b0000, 7'h00, 1'b1, 1, 1'b0, 16'h89AB);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_out("reset", 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 30; i++) begin
            frame_ack_i = tbl[i].ack;
            show(tbl[i].an, tbl[i].on, tbl[i].ncyc);
            check_out($sformatf("tbl[%0d]", i), tbl[i].rdy, tbl[i].frame, tbl[i].err);
        end
        frame_ack_i = 1'b0;

        // Short dwell then multi-hot glitch: digit 0 must not be captured.
        do_reset();
        show(4'b0001, 7'h7F, 3);
        show(4'b0011, 7'h7F, 2);
        gap(2);
        show(4'b0010, 7'h06, 6);
        show(4'b0100, 7'h5B, 6);
        show(4'b1000, 7'h4F, 6);
        gap(4);
        check_out("short_dwell", 1'b0, 16'h0000, 1'b0);
        show(4'b0001, 7'h7F, 6);
        gap(4);
        check_out("short_dwell_fill", 1'b1, 16'h3218, 1'b0);
        pulse_ack();

        // Blank pattern on digit 2: sticky error, digit stays unseen.
        do_reset();
        show(4'b0100, 7'h00, 6);
        gap(2);
        check("blank.err", {31'd0, err_o}, 32'd1);
        show(4'b0001, 7'h3F, 6);
        show(4'b0010, 7'h06, 6);
        show(4'b1000, 7'h4F, 6);
        gap(4);
        check_out("blank_unseen", 1'b0, 16'h0000, 1'b1);
        err_clr_i = 1'b1;
        gap(1);
        err_clr_i = 1'b0;
        check("err_clr", {31'd0, err_o}, 32'd0);
        gap(2);
        err_clr_i = 1'b1;
        show(4'b0100, 7'h00, 6);
        err_clr_i = 1'b0;
        check("err_set_vs_clr", {31'd0, err_o}, 32'd1);
        gap(2);
        show(4'b0100, 7'h5B, 6);
        gap(4);
        check_out("blank_refill", 1'b1, 16'h3210, 1'b1);
        pulse_ack();

        // Reset after three digits: all four must be re-seen.
        do_reset();
        show(4'b0001, 7'h3F, 6);
        show(4'b0010, 7'h06, 6);
        show(4'b0100, 7'h5B, 6);
        gap(2);
        do_reset();
        show(4'b1000, 7'h4F, 6);
        gap(4);
        check_out("rst_mid", 1'b0, 16'h0000, 1'b0);
        show(4'b0001, 7'h3F, 6);
        show(4'b0010, 7'h06, 6);
        show(4'b0100, 7'h5B, 6);
        gap(4);
        check_out("rst_refill", 1'b1, 16'h3210, 1'b0);
        pulse_ack();

`ifdef SEG7_DP_EN
        do_reset();
        dp_i = 1'b1;
        show(4'b0001, 7'h3F, 6);
        dp_i = 1'b0;
        show(4'b0010, 7'h06, 6);
        dp_i = 1'b1;
        show(4'b0100, 7'h5B, 6);
        show(4'b1000, 7'h4F, 6);
        gap(4);
        check("dp.frame_dp", {28'd0, frame_dp_o}, 32'h2);
        check_out("dp", 1'b1, 16'h3210, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
